// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard, write-to-read bypass
// and a one-register-per-cycle clear sweep (storage has a single write port).
module reg_file_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] data_c,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr,
    output logic              ready
);
    localparam int unsigned N = 2 ** ADDR_W;

    typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt, cnt_nx;
    logic [DATA_W-1:0]   mem [N];
    logic [N-1:0]        pend;

    logic                run;
    logic                wr_eff, rsv_eff;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic                zero_a, zero_b, hit_a, hit_b;

    // State and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            SWEEP: begin
                if (cnt == ADDR_W'(N - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    state_nx = SWEEP;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = SWEEP;
                cnt_nx   = '0;
            end
        endcase
    end

    assign run     = (state == RUN);
    assign ready   = run;
    assign wr_eff  = run & ~clr & w_en   & ~(ZERO_REG & (addr_c   == '0));
    assign rsv_eff = run & ~clr & rsv_en & ~(ZERO_REG & (rsv_addr == '0));

    // Single write port shared between the sweep and writeback
    assign mem_we = ~run | wr_eff;
    assign mem_wa = run ? addr_c : cnt;
    assign mem_wd = run ? data_c : '0;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Scoreboard: a reservation on the same edge as a writeback wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (!run) begin
            pend[cnt] <= 1'b0;
        end else begin
            if (wr_eff)  pend[addr_c]   <= 1'b0;
            if (rsv_eff) pend[rsv_addr] <= 1'b1;
        end
    end

    assign zero_a = ZERO_REG & (addr_a == '0);
    assign zero_b = ZERO_REG & (addr_b == '0);
    assign hit_a  = BYPASS & wr_eff & (addr_c == addr_a);
    assign hit_b  = BYPASS & wr_eff & (addr_c == addr_b);

    assign data_a = (!run || zero_a) ? '0 : (hit_a ? data_c : mem[addr_a]);
    assign data_b = (!run || zero_b) ? '0 : (hit_b ? data_c : mem[addr_b]);
    assign busy_a = run & ~zero_a & ~hit_a & pend[addr_a];
    assign busy_b = run & ~zero_b & ~hit_b & pend[addr_b];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (no zero-reg/bypass, zero-reg/no bypass)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_reg_file_sb;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addr_a = '0, addr_b = '0, addr_c = '0, rsv_addr = '0;
    logic [15:0] data_c = '0;
    logic        w_en = 1'b0, rsv_en = 1'b0, clr = 1'b0;

    logic [15:0] da0, db0, da1, db1;
    logic        ba0, bb0, ba1, bb1, rd0, rd1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: edges left in the current sweep, storage and pending bits
    int          sl = N;
    logic [15:0] mm [2][N];
    bit          pm [2][N];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b),
        .data_a(da0), .data_b(db0), .busy_a(ba0), .busy_b(bb0),
        .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr(clr), .ready(rd0));

    reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b),
        .data_a(da1), .data_b(db1), .busy_a(ba1), .busy_b(bb1),
        .w_en(w_en), .addr_c(addr_c), .data_c(data_c),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr(clr), .ready(rd1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instance 0: ZERO_REG=0, BYPASS=1; instance 1: ZERO_REG=1, BYPASS=0
    function automatic bit zr(input int i); return i == 1; endfunction
    function automatic bit bp(input int i); return i == 0; endfunction

    function automatic bit weff(input int i);
        return sl == 0 && !clr && w_en && !(zr(i) && addr_c == 4'd0);
    endfunction

    function automatic bit reff(input int i);
        return sl == 0 && !clr && rsv_en && !(zr(i) && rsv_addr == 4'd0);
    endfunction

    function automatic logic [15:0] exp_data(input int i, input logic [3:0] a);
        if (sl != 0 || (zr(i) && a == 4'd0)) return 16'h0000;
        if (bp(i) && weff(i) && addr_c == a) return data_c;
        return mm[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [3:0] a);
        if (sl != 0 || (zr(i) && a == 4'd0)) return 1'b0;
        if (bp(i) && weff(i) && addr_c == a) return 1'b0;
        return pm[i][a];
    endfunction

    // Reference model; the sweep only becomes observable once it completes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl <= N;
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < N; a++) pm[i][a] <= 1'b0;
        end else if (sl > 0) begin
            sl <= sl - 1;
            if (sl == 1)
                for (int i = 0; i < 2; i++)
                    for (int a = 0; a < N; a++) begin
                        mm[i][a] <= 16'h0000;
                        pm[i][a] <= 1'b0;
                    end
        end else if (clr) begin
            sl <= N;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (weff(i)) begin
                    mm[i][addr_c] <= data_c;
                    pm[i][addr_c] <= 1'b0;
                end
                if (reff(i)) pm[i][rsv_addr] <= 1'b1;
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [15:0] a_d, input logic [15:0] b_d,
                            input logic a_bz, input logic b_bz, input logic rdy);
        chk($sformatf("u%0d ready", i),  32'(rdy),  32'(sl == 0));
        chk($sformatf("u%0d data_a", i), 32'(a_d),  32'(exp_data(i, addr_a)));
        chk($sformatf("u%0d data_b", i), 32'(b_d),  32'(exp_data(i, addr_b)));
        chk($sformatf("u%0d busy_a", i), 32'(a_bz), 32'(exp_busy(i, addr_a)));
        chk($sformatf("u%0d busy_b", i), 32'(b_bz), 32'(exp_busy(i, addr_b)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, da0, db0, ba0, bb0, rd0);
            cmp_inst(1, da1, db1, ba1, bb1, rd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en = 1'b0; rsv_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (N) tick();

        // Load every register, then reset with the clock running
        for (int a = 0; a < N; a++) begin
            w_en = 1'b1; addr_c = 4'(a); data_c = 16'($urandom);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("reset sweep ready", 32'(rd0), 32'(k == N));
        end
        for (int a = 0; a < N; a++) begin
            addr_a = 4'(a); addr_b = 4'(N - 1 - a);
            #1;
            chk("swept data_a", 32'(da0), 32'h0);
            chk("swept busy_a", 32'(ba0), 32'h0);
            tick();
        end

        // Write/read with and without bypass
        addr_a = 4'd5; w_en = 1'b1; addr_c = 4'd5; data_c = 16'hBEEF;
        #1;
        chk("bypass data", 32'(da0), 32'h0000_BEEF);
        chk("no-bypass old data", 32'(da1), 32'h0);
        tick(); idle(); #1;
        chk("no-bypass new data", 32'(da1), 32'h0000_BEEF);

        // Zero register
        addr_a = 4'd0; w_en = 1'b1; addr_c = 4'd0; data_c = 16'h1234;
        rsv_en = 1'b1; rsv_addr = 4'd0;
        #1;
        chk("zero reg data", 32'(da1), 32'h0);
        chk("zero reg busy", 32'(ba1), 32'h0);
        tick(); idle(); #1;
        chk("zero reg data after", 32'(da1), 32'h0);
        chk("zero reg busy after", 32'(ba1), 32'h0);
        chk("reg0 normal data", 32'(da0), 32'h0000_1234);
        chk("reg0 normal busy", 32'(ba0), 32'h1);

        // Scoreboard on register 3
        addr_a = 4'd3; rsv_en = 1'b1; rsv_addr = 4'd3;
        #1;
        chk("rsv same-cycle busy", 32'(ba0), 32'h0);
        tick(); idle(); #1;
        chk("rsv busy u0", 32'(ba0), 32'h1);
        chk("rsv busy u1", 32'(ba1), 32'h1);
        w_en = 1'b1; addr_c = 4'd3; data_c = 16'h0033;
        #1;
        chk("wb bypass busy", 32'(ba0), 32'h0);
        chk("wb bypass data", 32'(da0), 32'h0000_0033);
        chk("wb no-bypass busy", 32'(ba1), 32'h1);
        tick(); idle(); #1;
        chk("wb released", 32'(ba1), 32'h0);
        chk("wb committed", 32'(da1), 32'h0000_0033);
        w_en = 1'b1; rsv_en = 1'b1; addr_c = 4'd3; rsv_addr = 4'd3; data_c = 16'h0C0C;
        tick(); idle(); #1;
        chk("rsv+wb data", 32'(da0), 32'h0000_0C0C);
        chk("rsv+wb busy", 32'(ba0), 32'h1);

        // Mid-run clear with a concurrent write
        addr_a = 4'd7; addr_b = 4'd3; clr = 1'b1;
        w_en = 1'b1; addr_c = 4'd7; data_c = 16'hAAAA;
        #1;
        chk("ready before clr", 32'(rd0), 32'h1);
        tick(); idle(); #1;
        chk("ready after clr edge", 32'(rd0), 32'h0);
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("clr sweep ready", 32'(rd0), 32'(k == N));
        end
        chk("clr dropped write", 32'(da0), 32'h0);
        chk("clr pend cleared", 32'(bb0), 32'h0);
        for (int a = 0; a < N; a++) begin
            addr_a = 4'(a);
            tick();
        end

        // Reset at sweep edge 9, clr inside the restarted sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            clr = (k == 5);
            tick();
            chk("rst mid-sweep ready", 32'(rd1), 32'(k == N));
        end
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 399) == 0);
            clr      = ($urandom_range(0, 63) == 0);
            w_en     = 1'($urandom);
            rsv_en   = 1'($urandom);
            addr_a   = 4'($urandom);
            addr_b   = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
            addr_c   = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
            rsv_addr = ($urandom_range(0, 3) == 0) ? addr_c : 4'($urandom);
            data_c   = 16'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
